// File: rtl/peak_bin_finder_if.sv
// Sample-stream and result bundle for peak_bin_finder.
// master drives samples and the noise floor; slave returns the frame result.
interface peak_bin_finder_if #(
  parameter int MAG_WIDTH = 32,
  parameter int BIN_WIDTH = 13
);
  logic [MAG_WIDTH-1:0] mag_in;
  logic                 mag_valid_in;
  logic                 mag_last_in;
  logic [MAG_WIDTH-1:0] threshold_in;
  logic [BIN_WIDTH-1:0] bin_index_out;
  logic [MAG_WIDTH-1:0] peak_mag_out;
  logic                 ready_out;
  logic                 overrun_out;

  modport master (
    output mag_in, mag_valid_in, mag_last_in, threshold_in,
    input  bin_index_out, peak_mag_out, ready_out, overrun_out
  );

  modport slave (
    input  mag_in, mag_valid_in, mag_last_in, threshold_in,
    output bin_index_out, peak_mag_out, ready_out, overrun_out
  );
endinterface

// File: rtl/peak_bin_finder.sv
// Per-frame peak search over bins [LO_BIN, HI_BIN] of a magnitude stream.
// Optional macro PEAK_BIN_THRESH_EN: suppress results not above threshold_in.
module peak_bin_finder #(
  parameter int MAG_WIDTH = 32,
  parameter int BIN_WIDTH = 13,
  parameter int LO_BIN    = 120,
  parameter int HI_BIN    = 4095
) (
  input logic               clk_in,
  input logic               rst_in,
  peak_bin_finder_if.slave  bus
);
  typedef enum logic {SCAN, REPORT} state_t;

  localparam logic [BIN_WIDTH-1:0] LO_B    = BIN_WIDTH'(LO_BIN);
  localparam logic [BIN_WIDTH-1:0] HI_B    = BIN_WIDTH'(HI_BIN);
  localparam logic [BIN_WIDTH-1:0] CNT_MAX = '1;

  state_t               r_state, w_state_next;
  logic [BIN_WIDTH-1:0] r_cnt;
  logic [BIN_WIDTH-1:0] r_best_bin;
  logic [MAG_WIDTH-1:0] r_best_mag;
  logic [BIN_WIDTH-1:0] r_bin_out;
  logic [MAG_WIDTH-1:0] r_mag_out;
  logic                 r_ready;
  logic                 r_overrun;

  logic                 w_accept, w_last, w_wrap, w_eligible, w_take;
  logic [BIN_WIDTH-1:0] w_final_bin, w_report_bin;
  logic [MAG_WIDTH-1:0] w_final_mag, w_report_mag;

  assign w_accept   = bus.mag_valid_in;
  assign w_last     = w_accept & bus.mag_last_in;
  assign w_wrap     = w_accept & ~bus.mag_last_in & (r_cnt == CNT_MAX);
  assign w_eligible = (r_cnt >= LO_B) && (r_cnt <= HI_B);
  // Strict compare keeps the earlier (lower) bin on ties.
  assign w_take     = w_accept && w_eligible && (bus.mag_in > r_best_mag);

  // The last sample competes before the result is latched.
  assign w_final_bin = w_take ? r_cnt      : r_best_bin;
  assign w_final_mag = w_take ? bus.mag_in : r_best_mag;

`ifdef PEAK_BIN_THRESH_EN
  always_comb begin
    w_report_bin = '0;
    w_report_mag = '0;
    if (w_final_mag > bus.threshold_in) begin
      w_report_bin = w_final_bin;
      w_report_mag = w_final_mag;
    end
  end
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^bus.threshold_in;
  assign w_report_bin    = w_final_bin;
  assign w_report_mag    = w_final_mag;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SCAN:    if (w_last) w_state_next = REPORT;
      REPORT:  w_state_next = SCAN;
      default: w_state_next = SCAN;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= SCAN;
      r_cnt      <= '0;
      r_best_bin <= '0;
      r_best_mag <= '0;
      r_bin_out  <= '0;
      r_mag_out  <= '0;
      r_ready    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Pulses for every accepted last, so a one-sample frame landing in REPORT still reports.
      r_ready <= w_last;
      if (w_last) begin
        r_cnt      <= '0;
        r_best_bin <= '0;
        r_best_mag <= '0;
        r_bin_out  <= w_report_bin;
        r_mag_out  <= w_report_mag;
      end else if (w_wrap) begin
        r_cnt      <= '0;
        r_best_bin <= '0;
        r_best_mag <= '0;
        r_overrun  <= 1'b1;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_take) begin
          r_best_bin <= r_cnt;
          r_best_mag <= bus.mag_in;
        end
      end
    end
  end

  assign bus.bin_index_out = r_bin_out;
  assign bus.peak_mag_out  = r_mag_out;
  assign bus.ready_out     = r_ready;
  assign bus.overrun_out   = r_overrun;
endmodule

// File: tb/tb_peak_bin_finder.sv
// Scoreboard bench for peak_bin_finder: driver pushes model results, monitor pops on ready_out.
// Define PEAK_BIN_THRESH_EN here as for the RTL to exercise the threshold build.
module tb_peak_bin_finder;
  localparam int MW   = 32;
  localparam int BW   = 13;
  localparam int LO   = 120;
  localparam int HI   = 4095;
  localparam int NMAX = 8192;

  typedef struct {
    int unsigned bin;
    logic [31:0] mag;
    longint      cyc;
  } exp_t;

  logic   clk_in = 1'b0;
  logic   rst_in = 1'b0;
  longint cyc = 0;
  int     total = 0;
  int     bad = 0;
  exp_t   exp_q[$];
  logic [31:0] frame_mag[NMAX];
  logic [31:0] thr = 0;
  logic [31:0] held_bin = 0;
  logic [31:0] held_mag = 0;
  int     frame_no = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  peak_bin_finder_if #(.MAG_WIDTH(MW), .BIN_WIDTH(BW)) bus();

  peak_bin_finder #(
    .MAG_WIDTH(MW), .BIN_WIDTH(BW), .LO_BIN(LO), .HI_BIN(HI)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Reference: the largest magnitude among eligible bins, first occurrence wins.
  function automatic exp_t model(input int n, input longint c);
    exp_t e;
    e.bin = 0;
    e.mag = 0;
    e.cyc = c;
    for (int i = LO; i <= HI && i < n; i++)
      if (frame_mag[i] > e.mag) begin
        e.mag = frame_mag[i];
        e.bin = i;
      end
`ifdef PEAK_BIN_THRESH_EN
    if (!(e.mag > thr)) begin
      e.bin = 0;
      e.mag = 0;
    end
`endif
    return e;
  endfunction

  task automatic clear_frame(input int n);
    for (int i = 0; i < n; i++) frame_mag[i] = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.mag_valid_in = 1'b0;
      bus.mag_in       = $urandom;
      bus.mag_last_in  = 1'($urandom_range(1));
      @(posedge clk_in); #1;
    end
    bus.mag_valid_in = 1'b0;
    bus.mag_last_in  = 1'b0;
  endtask

  // Called at #1 after a rising edge; each sample is taken on the next edge.
  task automatic send_frame(input int n, input int gap_pct, input bit with_last);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        bus.mag_valid_in = 1'b0;
        bus.mag_in       = $urandom;
        bus.mag_last_in  = 1'($urandom_range(1));
        @(posedge clk_in); #1;
      end
      bus.mag_valid_in = 1'b1;
      bus.mag_in       = frame_mag[i];
      bus.mag_last_in  = with_last && (i == n - 1);
      bus.threshold_in = thr;
      if (with_last && i == n - 1) exp_q.push_back(model(n, cyc + 1));
      @(posedge clk_in); #1;
    end
    bus.mag_valid_in = 1'b0;
    bus.mag_last_in  = 1'b0;
  endtask

  always @(negedge clk_in) begin
    if (!rst_in) begin
      check("rst_bin", 64'(bus.bin_index_out), 0);
      check("rst_mag", 64'(bus.peak_mag_out), 0);
      check("rst_ready", 64'(bus.ready_out), 0);
      check("rst_overrun", 64'(bus.overrun_out), 0);
      held_bin = 0;
      held_mag = 0;
    end else if (bus.ready_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ready_cycle", 64'(cyc), 64'(e.cyc));
        check("peak_bin", 64'(bus.bin_index_out), 64'(e.bin));
        check("peak_mag", 64'(bus.peak_mag_out), 64'(e.mag));
        $display("frame %0d: bin=%0d mag=%0d (expected bin=%0d mag=%0d) at cycle %0d",
                 frame_no, bus.bin_index_out, bus.peak_mag_out, e.bin, e.mag, cyc);
        frame_no++;
        held_bin = e.bin;
        held_mag = e.mag;
      end
    end else begin
      check("hold_bin", 64'(bus.bin_index_out), 64'(held_bin));
      check("hold_mag", 64'(bus.peak_mag_out), 64'(held_mag));
    end
  end

  initial begin
    bus.mag_in       = 0;
    bus.mag_valid_in = 1'b0;
    bus.mag_last_in  = 1'b0;
    bus.threshold_in = 0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b1;
    thr = $urandom_range(0, 3000);
`ifdef PEAK_BIN_THRESH_EN
    thr = 0;
`endif

    // Single peak in a half-spectrum frame.
    clear_frame(4096); frame_mag[300] = 1000;
    send_frame(4096, 0, 1'b1);
    idle(3);

    // Out-of-range bin ignored, with random gaps.
    clear_frame(256); frame_mag[50] = 9999; frame_mag[200] = 500;
    send_frame(256, 20, 1'b1);

    // Tie goes to the lower bin.
    clear_frame(500); frame_mag[400] = 777; frame_mag[410] = 777;
    send_frame(500, 10, 1'b1);
    idle(2);

    // Back-to-back frames, no idle cycle between them.
    clear_frame(4096); frame_mag[150] = 600;
    send_frame(4096, 0, 1'b1);
    clear_frame(4096); frame_mag[250] = 600;
    send_frame(4096, 0, 1'b1);
    idle(2);

    // Range edges: 119 and 4096 excluded, 120 and 4095 tie -> 120.
    clear_frame(4200);
    frame_mag[119] = 99999; frame_mag[4096] = 88888;
    frame_mag[120] = 5;     frame_mag[4095] = 5;
    send_frame(4200, 0, 1'b1);

    // All-zero frame and a frame too short to reach LO.
    clear_frame(300);
    send_frame(300, 5, 1'b1);
    for (int i = 0; i < 50; i++) frame_mag[i] = $urandom;
    send_frame(50, 5, 1'b1);

`ifdef PEAK_BIN_THRESH_EN
    thr = 2000;
    clear_frame(400); frame_mag[300] = 1500;
    send_frame(400, 0, 1'b1);
    thr = 2000;
    clear_frame(400); frame_mag[300] = 2001;
    send_frame(400, 0, 1'b1);
`endif

    // Random frames with small magnitudes so ties are common.
    for (int f = 0; f < 12; f++) begin
      int n;
      n = $urandom_range(1, 700);
      for (int i = 0; i < n; i++) frame_mag[i] = $urandom_range(0, 40);
`ifdef PEAK_BIN_THRESH_EN
      thr = $urandom_range(0, 45);
`else
      thr = $urandom;
`endif
      send_frame(n, 30, 1'b1);
      if ($urandom_range(1)) idle($urandom_range(1, 4));
    end
    thr = 0;
    idle(3);

    // Mid-frame reset at bin 1000 discards the partial frame.
    for (int i = 0; i < 1000; i++) frame_mag[i] = $urandom;
    send_frame(1000, 0, 1'b0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    idle(1);
    for (int i = 0; i < 400; i++) frame_mag[i] = $urandom_range(0, 100);
    frame_mag[130] = 5000;
    send_frame(400, 0, 1'b1);
    idle(3);

    // 8192 samples with no last: overrun, no result.
    check("overrun_before", 64'(bus.overrun_out), 0);
    clear_frame(NMAX); frame_mag[300] = 7;
    send_frame(NMAX, 0, 1'b0);
    idle(3);
    check("overrun_set", 64'(bus.overrun_out), 1);
    for (int i = 0; i < 200; i++) frame_mag[i] = $urandom_range(0, 1000);
    send_frame(200, 0, 1'b1);
    idle(3);
    check("overrun_sticky", 64'(bus.overrun_out), 1);
    rst_in = 1'b0;
    #2;
    check("overrun_cleared", 64'(bus.overrun_out), 0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    idle(5);

    check("pending_results", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/peak_bin_finder.md
PEAK_BIN_FINDER -- requirements
Module: peak_bin_finder

Interface
REQ-001 SHALL have parameter MAG_WIDTH, default 32: width of the unsigned squared-magnitude samples.
REQ-002 SHALL have parameter BIN_WIDTH, default 13: width of the bin counter and the bin index output.
REQ-003 SHALL have parameter LO_BIN, default 120: lowest bin eligible as the peak.
REQ-004 SHALL have parameter HI_BIN, default 4095: highest bin eligible as the peak; only the first half of a 8192-point FFT is searched.
REQ-005 SHALL have port clk_in, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_in, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port mag_in, input, MAG_WIDTH bits: magnitude of the current bin.
REQ-008 SHALL have port mag_valid_in, input, 1 bit: mag_in is valid this cycle; the block never stalls, so every valid sample is accepted.
REQ-009 SHALL have port mag_last_in, input, 1 bit: qualifies the final bin of a frame; meaningful only with mag_valid_in.
REQ-010 SHALL have port threshold_in, input, MAG_WIDTH bits: noise floor, used only under THRESH_EN.
REQ-011 SHALL have port bin_index_out, output, BIN_WIDTH bits: bin of the frame peak, 0 if no qualifying peak.
REQ-012 SHALL have port peak_mag_out, output, MAG_WIDTH bits: magnitude at bin_index_out, 0 if none.
REQ-013 SHALL have port ready_out, output, 1 bit: one-cycle pulse, new result present.
REQ-014 SHALL have port overrun_out, output, 1 bit: sticky flag, a frame exceeded 2^BIN_WIDTH samples.

Function
REQ-015 SHALL run a bin counter: zeroed at reset and after each accepted last sample, incremented on each accepted non-last sample; the counter value is the bin of the current sample.
REQ-016 SHALL keep a running best (bin, magnitude), cleared to (0,0) at frame start, replaced only when the sample bin is within [LO_BIN, HI_BIN] and mag_in is strictly greater than the best; on ties the lower bin wins.
REQ-017 SHALL use FSM states SCAN and REPORT: SCAN to REPORT on an accepted last sample; REPORT to SCAN unconditionally after one cycle.
REQ-018 SHALL, on the cycle after the accepted last sample (the REPORT state), assert ready_out for exactly one cycle with bin_index_out and peak_mag_out already updated to the frame result; the last sample itself takes part in the comparison.
REQ-019 SHALL hold bin_index_out and peak_mag_out stable from a result until the next ready_out pulse, because the consumer re-reads them over many cycles.
REQ-020 SHALL accept a valid sample arriving during REPORT as bin 0 of the next frame, with no loss; back-to-back frames are supported at one sample per clock.
REQ-021 SHALL, for a frame with no eligible bin or an all-zero magnitude, report bin 0 and magnitude 0 and still pulse ready_out.
REQ-022 SHALL, when the counter would wrap past 2^BIN_WIDTH-1 without mag_last_in, set overrun_out, discard the frame (no ready_out) and restart counting at bin 0.
REQ-023 SHALL ignore mag_last_in and mag_in on cycles where mag_valid_in is low; gaps between samples SHALL NOT affect the result.

Reset
REQ-024 SHALL, while rst_in is low, immediately force the state to SCAN, the counter and best to 0, bin_index_out 0, peak_mag_out 0, ready_out 0 and overrun_out 0.
REQ-025 SHALL discard a partially received frame on a mid-frame reset; the first valid sample after release is bin 0.
REQ-026 SHALL clear overrun_out only by reset.

Configuration
REQ-027 SHALL, with macro PEAK_BIN_THRESH_EN defined, report bin 0 and magnitude 0 when the best magnitude is not strictly greater than threshold_in, sampled on the last-sample cycle; without the macro, threshold_in SHALL be ignored and the raw best SHALL be reported.

Verification
REQ-028 SHALL be covered by this directed scenario: frame of 4096 samples, all 0 except bin 300 = 1000 -> ready_out one cycle after the last sample, bin 300, magnitude 1000.
REQ-029 SHALL be covered by this directed scenario: bin 50 = 9999 and bin 200 = 500 -> bin 200, magnitude 500 (out of range ignored).
REQ-030 SHALL be covered by this directed scenario: bins 400 and 410 both = 777 -> bin 400.
REQ-031 SHALL be covered by this directed scenario: two back-to-back frames with no idle cycle, peaks 150 then 250 -> two ready_out pulses 4096 cycles apart, outputs 150 held, then 250.
REQ-032 SHALL be covered by this directed scenario: PEAK_BIN_THRESH_EN defined, threshold_in 2000, peak 1500 at bin 300 -> bin 0, magnitude 0, ready_out still pulses.
REQ-033 SHALL be covered by this directed scenario: rst_in low at bin 1000 of a frame, then a full frame with peak at 130 -> single ready_out, bin 130; 8192 samples with no last -> overrun_out 1 and no ready_out.
